rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Shares the regfile's single write port between pipeline writeback (1-cycle ALU/load) and the multi-cycle MUL/DIV unit (MDU).
//  Holds a scoreboard of registers owned by in-flight MDU ops and flags read/WAW hazards to decode.
//  Drives regfile reg_write/rd/wd directly. Forces the pipeline to stall when an MDU result has waited too long.
// PARAMETERS
//  XLEN      32  datapath width
//  NREG      32  architectural registers; x0 is hard-wired zero
//  MAX_WAIT  4   cycles an MDU result may be refused before a forced grant (>=1)
// PORTS
//  clk           in   1     system clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  wb_valid      in   1     pipeline writeback request this cycle
//  wb_rd         in   5     pipeline destination register
//  wb_data       in   XLEN  pipeline writeback data
//  wb_stall      out  1     pipeline must hold (forced MDU slot)
//  mdu_valid     in   1     MDU result available
//  mdu_rd        in   5     MDU result destination
//  mdu_data      in   XLEN  MDU result data
//  mdu_ready     out  1     MDU result accepted this cycle
//  iss_valid     in   1     decode issues an MDU op
//  iss_rd        in   5     destination of issued MDU op
//  iss_ok        out  1     issue accepted (iss_rd not pending)
//  rs1, rs2, id_rd in 5 each  decode-stage lookups
//  hazard        out  1     rs1/rs2/id_rd pending (x0 never pending)
//  rf_reg_write  out  1     regfile write enable
//  rf_rd         out  5     regfile write address
//  rf_wd         out  XLEN  regfile write data
//  sb_err        out  1     sticky: MDU result for a non-pending rd
// BEHAVIOUR
//  Reset: pending=0, wait_cnt=0, state=ARB_PIPE, sb_err=0. All outputs 0 with idle inputs.
//  FSM ARB_PIPE: pipeline has priority. wb_valid && wb_rd!=0 -> rf_* = wb_*, mdu_ready=0.
//    Otherwise mdu_ready=mdu_valid and rf_* = mdu_*. Pipeline wb to x0 consumes no slot.
//  wait_cnt: +1 each cycle mdu_valid && !mdu_ready, saturating at MAX_WAIT. Cleared on grant or !mdu_valid.
//    At wait_cnt==MAX_WAIT-1 with still no grant -> next state ARB_FORCE.
//  ARB_FORCE (1 cycle): wb_stall=1, mdu granted unconditionally; pipeline keeps its request. Next state ARB_PIPE, wait_cnt=0.
//  rf_reg_write never asserts for rd==0. MDU result to x0 is accepted and dropped.
//  Write is combinational to the regfile port; the regfile commits on the same clk edge, so latency is 0 cycles.
//  Scoreboard: iss_ok = !pending[iss_rd] || iss_rd==0.
//    iss_valid && iss_ok && iss_rd!=0 sets pending next edge. MDU grant clears pending[mdu_rd] next edge.
//    Same-edge set and clear on the same rd is impossible because iss_ok=0 while that rd is pending.
//  hazard is combinational from pending. id_rd is included to block pipeline WAW on an MDU-owned register.
//  mdu_valid with pending[mdu_rd]==0 && mdu_rd!=0 -> sb_err=1 (sticky); write still performed.
//  Reset mid-operation clears all pending bits; the MDU is reset by the same rst.
// CONFIGURATION
//  RF_WB_FWD_EN defined: if rs1/rs2 equals the MDU rd granted this cycle, that operand's hazard is suppressed.
//    Extra outputs fwd_rs1, fwd_rs2 (1 bit each) and fwd_data=mdu_data are added.
//  Undefined: no fwd ports; hazard holds until the cycle after the grant.
// STRUCTURE
//  Package rv_rf_pkg: arb_state_t {ARB_PIPE, ARB_FORCE}, REG_X0='0, XLEN, regaddr_t (logic [4:0]).
//  Sub-module rf_scoreboard: pending vector, set/clear, three lookup ports, iss_ok.
//  Top-level logic: arbiter FSM, wait counter, write mux, sb_err.
// TESTING
//  Back-to-back wb (x3=CAFEBABE, x5=DEADBEEF), no MDU -> rf writes the same cycle, mdu_ready=0, hazard=0.
//  iss x7 -> next cycle pending; rs1=7 -> hazard=1.
//    mdu_valid rd=7 with idle pipe -> granted, x7 written, hazard=0 one cycle later.
//  mdu_valid rd=9 while wb_valid every cycle, MAX_WAIT=4 -> refused 4 cycles, then wb_stall=1 for 1 cycle and x9 written.
//    Pipe write lands the cycle after.
//  wb_rd=0 data FFFFFFFF -> rf_reg_write=0. Concurrent mdu_valid is granted in the same cycle.
//  iss x7 while x7 pending -> iss_ok=0. mdu result rd=12 never issued -> sb_err=1 until rst.
//  rst asserted with 3 pending regs mid-wait -> pending cleared, FSM=ARB_PIPE, wait_cnt=0 immediately.
//    With FWD_EN: rs2=7 in the grant cycle -> hazard=0, fwd_rs2=1.

Source files
------------

// File: rtl/rv_rf_pkg.sv
// Shared types and constants for the regfile writeback scheduler.
package rv_rf_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] regaddr_t;

   localparam regaddr_t REG_X0 = '0;

   typedef enum logic {
      ARB_PIPE  = 1'b0,
      ARB_FORCE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-register scoreboard for in-flight MDU ops: set on accepted issue,
// cleared on MDU grant, with decode lookups and an issue-accept check.
module rf_scoreboard
   import rv_rf_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     iss_valid,
   input  regaddr_t iss_rd,
   output logic     iss_ok,
   input  logic     clr_en,
   input  regaddr_t clr_rd,
   input  regaddr_t rs1,
   input  regaddr_t rs2,
   input  regaddr_t id_rd,
   input  regaddr_t chk_rd,
   output logic     pend_rs1,
   output logic     pend_rs2,
   output logic     pend_id_rd,
   output logic     pend_chk
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic            set_en;

   assign iss_ok = iss_valid && (!pending_q[iss_rd] || (iss_rd == REG_X0));
   assign set_en = iss_ok && (iss_rd != REG_X0);

   // Set and clear never collide on one rd: iss_ok is low while that rd is pending.
   always_comb begin
      pending_d = pending_q;
      if (set_en) pending_d[iss_rd] = 1'b1;
      if (clr_en) pending_d[clr_rd] = 1'b0;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   assign pend_rs1   = pending_q[rs1];
   assign pend_rs2   = pending_q[rs2];
   assign pend_id_rd = pending_q[id_rd];
   assign pend_chk   = pending_q[chk_rd];

endmodule

// File: rtl/rf_wb_scheduler.sv
// Regfile write-port arbiter between pipeline writeback and the MDU, with
// hazard scoreboard. Define RF_WB_FWD_EN to add same-cycle MDU forwarding.
module rf_wb_scheduler #(
   parameter int XLEN     = rv_rf_pkg::XLEN,
   parameter int NREG     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wb_valid,
   input  rv_rf_pkg::regaddr_t           wb_rd,
   input  logic [XLEN-1:0]               wb_data,
   output logic                          wb_stall,
   input  logic                          mdu_valid,
   input  rv_rf_pkg::regaddr_t           mdu_rd,
   input  logic [XLEN-1:0]               mdu_data,
   output logic                          mdu_ready,
   input  logic                          iss_valid,
   input  rv_rf_pkg::regaddr_t           iss_rd,
   output logic                          iss_ok,
   input  rv_rf_pkg::regaddr_t           rs1,
   input  rv_rf_pkg::regaddr_t           rs2,
   input  rv_rf_pkg::regaddr_t           id_rd,
   output logic                          hazard,
   output logic                          rf_reg_write,
   output rv_rf_pkg::regaddr_t           rf_rd,
   output logic [XLEN-1:0]               rf_wd,
   output logic                          sb_err,
`ifdef RF_WB_FWD_EN
   output logic                          fwd_rs1,
   output logic                          fwd_rs2,
   output logic [XLEN-1:0]               fwd_data,
`endif
   output rv_rf_pkg::arb_state_t         dbg_state,
   output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait_cnt
);
   import rv_rf_pkg::*;

   localparam int WCW = $clog2(MAX_WAIT + 1);
   typedef logic [WCW-1:0] wcnt_t;
   localparam wcnt_t WAIT_LAST = wcnt_t'(MAX_WAIT - 1);
   localparam wcnt_t WAIT_MAX  = wcnt_t'(MAX_WAIT);

   arb_state_t state_q, state_d;
   wcnt_t      wait_q, wait_d;
   logic       sb_err_q, sb_err_d;
   logic       pipe_req, mdu_grant;
   logic       pend_rs1, pend_rs2, pend_id_rd, pend_chk;

   rf_scoreboard #(.NREG(NREG)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .iss_ok     (iss_ok),
      .clr_en     (mdu_grant),
      .clr_rd     (mdu_rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .id_rd      (id_rd),
      .chk_rd     (mdu_rd),
      .pend_rs1   (pend_rs1),
      .pend_rs2   (pend_rs2),
      .pend_id_rd (pend_id_rd),
      .pend_chk   (pend_chk)
   );

   // Valid/ready: an MDU result transfers in a cycle where mdu_valid && mdu_ready;
   // the MDU holds mdu_rd/mdu_data stable until then. A pipeline write to x0 never claims the port.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      wb_stall     = 1'b0;
      mdu_ready    = 1'b0;
      rf_reg_write = 1'b0;
      rf_rd        = REG_X0;
      rf_wd        = '0;
      pipe_req     = wb_valid && (wb_rd != REG_X0);

      case (state_q)
         ARB_FORCE: begin
            wb_stall  = 1'b1;
            mdu_ready = mdu_valid;
         end
         default: mdu_ready = mdu_valid && !pipe_req;
      endcase

      mdu_grant = mdu_valid && mdu_ready;

      if (mdu_grant) begin
         if (mdu_rd != REG_X0) begin
            rf_reg_write = 1'b1;
            rf_rd        = mdu_rd;
            rf_wd        = mdu_data;
         end
      end else if (pipe_req && (state_q == ARB_PIPE)) begin
         rf_reg_write = 1'b1;
         rf_rd        = wb_rd;
         rf_wd        = wb_data;
      end

      if (state_q == ARB_FORCE) begin
         state_d = ARB_PIPE;
         wait_d  = '0;
      end else if (!mdu_valid || mdu_grant) begin
         wait_d = '0;
      end else begin
         if (wait_q >= WAIT_LAST) state_d = ARB_FORCE;
         if (wait_q != WAIT_MAX)  wait_d  = wait_q + wcnt_t'(1);
      end

      sb_err_d = sb_err_q || (mdu_valid && !pend_chk && (mdu_rd != REG_X0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_PIPE;
         wait_q   <= '0;
         sb_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         sb_err_q <= sb_err_d;
      end
   end

`ifdef RF_WB_FWD_EN
   // An operand matching this cycle's MDU grant takes the result from the bypass instead of stalling.
   assign fwd_rs1  = mdu_grant && (mdu_rd == rs1) && (rs1 != REG_X0);
   assign fwd_rs2  = mdu_grant && (mdu_rd == rs2) && (rs2 != REG_X0);
   assign fwd_data = mdu_data;
   assign hazard   = (pend_rs1 && !fwd_rs1) || (pend_rs2 && !fwd_rs2) || pend_id_rd;
`else
   assign hazard   = pend_rs1 || pend_rs2 || pend_id_rd;
`endif

   assign sb_err       = sb_err_q;
   assign dbg_state    = state_q;
   assign dbg_wait_cnt = wait_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (MAX_WAIT=4).
module tb_rf_wb_scheduler;
   import rv_rf_pkg::*;

   logic             clk, rst;
   logic             wb_valid, mdu_valid, iss_valid;
   regaddr_t         wb_rd, mdu_rd, iss_rd, rs1, rs2, id_rd;
   logic [31:0]      wb_data, mdu_data;
   logic             wb_stall, mdu_ready, iss_ok, hazard, rf_reg_write, sb_err;
   regaddr_t         rf_rd;
   logic [31:0]      rf_wd;
   arb_state_t       dbg_state;
   logic [2:0]       dbg_wait_cnt;
`ifdef RF_WB_FWD_EN
   logic             fwd_rs1, fwd_rs2;
   logic [31:0]      fwd_data;
`endif

   int vectors = 0;
   int miscompares = 0;

   rf_wb_scheduler #(.XLEN(32), .NREG(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ok(iss_ok),
      .rs1(rs1), .rs2(rs2), .id_rd(id_rd), .hazard(hazard),
      .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_wd(rf_wd), .sb_err(sb_err),
`ifdef RF_WB_FWD_EN
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_data(fwd_data),
`endif
      .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic idle_inputs();
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
      iss_valid = 0; iss_rd = 0;
      rs1 = 0; rs2 = 0; id_rd = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) tick();
      vectors++; if ({wb_stall, mdu_ready, iss_ok, hazard, rf_reg_write, sb_err} !== 6'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b exp 000000", {wb_stall, mdu_ready, iss_ok, hazard, rf_reg_write, sb_err}); end
      vectors++; if ({rf_rd, rf_wd} !== 37'h0) begin
         miscompares++; $display("FAIL reset_rf: got rd=%0d wd=%h exp 0/0", rf_rd, rf_wd); end
      vectors++; if (dbg_state !== ARB_PIPE || dbg_wait_cnt !== 3'd0) begin
         miscompares++; $display("FAIL reset_fsm: got st=%0d cnt=%0d exp 0/0", dbg_state, dbg_wait_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hCAFEBABE; #1;
      vectors++; if ({rf_reg_write, rf_rd, rf_wd} !== {1'b1, 5'd3, 32'hCAFEBABE}) begin
         miscompares++; $display("FAIL b2b_x3: got we=%b rd=%0d wd=%h exp 1/3/cafebabe", rf_reg_write, rf_rd, rf_wd); end
      vectors++; if (mdu_ready !== 1'b0 || hazard !== 1'b0) begin
         miscompares++; $display("FAIL b2b_x3_side: got rdy=%b hz=%b exp 0/0", mdu_ready, hazard); end
      tick();
      wb_rd = 5'd5; wb_data = 32'hDEADBEEF; #1;
      vectors++; if ({rf_reg_write, rf_rd, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         miscompares++; $display("FAIL b2b_x5: got we=%b rd=%0d wd=%h exp 1/5/deadbeef", rf_reg_write, rf_rd, rf_wd); end
      tick();
      idle_inputs();
   endtask

   task automatic test_issue_hazard();
      iss_valid = 1; iss_rd = 5'd7; #1;
      vectors++; if (iss_ok !== 1'b1) begin
         miscompares++; $display("FAIL iss7_ok: got %b exp 1", iss_ok); end
      tick();
      iss_valid = 0; rs1 = 5'd7; #1;
      vectors++; if (hazard !== 1'b1) begin
         miscompares++; $display("FAIL iss7_hazard: got %b exp 1", hazard); end
      tick();
      mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h12345678; #1;
      vectors++; if ({mdu_ready, rf_reg_write, rf_rd, rf_wd} !== {2'b11, 5'd7, 32'h12345678}) begin
         miscompares++; $display("FAIL mdu7_grant: got rdy=%b we=%b rd=%0d wd=%h exp 1/1/7/12345678", mdu_ready, rf_reg_write, rf_rd, rf_wd); end
`ifndef RF_WB_FWD_EN
      vectors++; if (hazard !== 1'b1) begin
         miscompares++; $display("FAIL mdu7_hazard_grant: got %b exp 1", hazard); end
`endif
      tick();
      mdu_valid = 0; #1;
      vectors++; if (hazard !== 1'b0 || sb_err !== 1'b0) begin
         miscompares++; $display("FAIL mdu7_after: got hz=%b err=%b exp 0/0", hazard, sb_err); end
      tick();
      idle_inputs();
   endtask

   task automatic test_iss_busy();
      iss_valid = 1; iss_rd = 5'd7;
      tick();
      #1;
      vectors++; if (iss_ok !== 1'b0) begin
         miscompares++; $display("FAIL iss7_busy: got %b exp 0", iss_ok); end
      iss_valid = 0; id_rd = 5'd7; #1;
      vectors++; if (hazard !== 1'b1) begin
         miscompares++; $display("FAIL waw_id_rd: got %b exp 1", hazard); end
      mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h77;
      tick();
      idle_inputs(); #1;
      vectors++; if (hazard !== 1'b0) begin
         miscompares++; $display("FAIL iss7_cleared: got %b exp 0", hazard); end
   endtask

   task automatic test_force();
      iss_valid = 1; iss_rd = 5'd9;
      tick();
      iss_valid = 0;
      wb_valid = 1; wb_rd = 5'd10; wb_data = 32'hA0;
      mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h99;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++; if ({mdu_ready, wb_stall, rf_rd, dbg_wait_cnt} !== {2'b00, 5'd10, 3'(k)}) begin
            miscompares++; $display("FAIL force_refuse%0d: got rdy=%b st=%b rd=%0d cnt=%0d exp 0/0/10/%0d", k, mdu_ready, wb_stall, rf_rd, dbg_wait_cnt, k); end
         tick();
      end
      #1;
      vectors++; if ({wb_stall, mdu_ready, rf_reg_write, rf_rd, rf_wd} !== {3'b111, 5'd9, 32'h99}) begin
         miscompares++; $display("FAIL force_grant: got st=%b rdy=%b we=%b rd=%0d wd=%h exp 1/1/1/9/99", wb_stall, mdu_ready, rf_reg_write, rf_rd, rf_wd); end
      vectors++; if (dbg_state !== ARB_FORCE) begin
         miscompares++; $display("FAIL force_state: got %0d exp 1", dbg_state); end
      tick();
      mdu_valid = 0; rs1 = 5'd9; #1;
      vectors++; if ({wb_stall, rf_reg_write, rf_rd, rf_wd} !== {2'b01, 5'd10, 32'hA0}) begin
         miscompares++; $display("FAIL force_pipe_after: got st=%b we=%b rd=%0d wd=%h exp 0/1/10/a0", wb_stall, rf_reg_write, rf_rd, rf_wd); end
      vectors++; if (dbg_state !== ARB_PIPE || dbg_wait_cnt !== 3'd0 || hazard !== 1'b0) begin
         miscompares++; $display("FAIL force_return: got st=%0d cnt=%0d hz=%b exp 0/0/0", dbg_state, dbg_wait_cnt, hazard); end
      tick();
      idle_inputs();
   endtask

   task automatic test_x0();
      iss_valid = 1; iss_rd = 5'd11;
      tick();
      iss_valid = 0;
      wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; #1;
      vectors++; if (rf_reg_write !== 1'b0 || mdu_ready !== 1'b0) begin
         miscompares++; $display("FAIL x0_wb: got we=%b rdy=%b exp 0/0", rf_reg_write, mdu_ready); end
      tick();
      mdu_valid = 1; mdu_rd = 5'd11; mdu_data = 32'h0B0B0B0B; #1;
      vectors++; if ({mdu_ready, wb_stall, rf_reg_write, rf_rd, rf_wd} !== {3'b101, 5'd11, 32'h0B0B0B0B}) begin
         miscompares++; $display("FAIL x0_wb_mdu: got rdy=%b st=%b we=%b rd=%0d wd=%h exp 1/0/1/11/0b0b0b0b", mdu_ready, wb_stall, rf_reg_write, rf_rd, rf_wd); end
      tick();
      wb_valid = 0; mdu_rd = 5'd0; mdu_data = 32'h5555; #1;
      vectors++; if (mdu_ready !== 1'b1 || rf_reg_write !== 1'b0) begin
         miscompares++; $display("FAIL x0_mdu: got rdy=%b we=%b exp 1/0", mdu_ready, rf_reg_write); end
      tick();
      idle_inputs(); #1;
      vectors++; if (sb_err !== 1'b0) begin
         miscompares++; $display("FAIL x0_no_err: got %b exp 0", sb_err); end
   endtask

   task automatic test_sb_err();
      mdu_valid = 1; mdu_rd = 5'd12; mdu_data = 32'hC; #1;
      vectors++; if ({mdu_ready, rf_reg_write, rf_rd, sb_err} !== {2'b11, 5'd12, 1'b0}) begin
         miscompares++; $display("FAIL err12_write: got rdy=%b we=%b rd=%0d err=%b exp 1/1/12/0", mdu_ready, rf_reg_write, rf_rd, sb_err); end
      tick();
      idle_inputs();
      repeat (3) tick();
      vectors++; if (sb_err !== 1'b1) begin
         miscompares++; $display("FAIL err12_sticky: got %b exp 1", sb_err); end
   endtask

   task automatic test_reset_mid();
      for (int r = 1; r <= 3; r++) begin
         iss_valid = 1; iss_rd = 5'(r);
         tick();
      end
      iss_valid = 0;
      wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h4;
      mdu_valid = 1; mdu_rd = 5'd1; mdu_data = 32'h1;
      repeat (2) tick();
      rs1 = 5'd1; rs2 = 5'd2; id_rd = 5'd3; #1;
      vectors++; if (dbg_wait_cnt !== 3'd2 || hazard !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_pre: got cnt=%0d hz=%b exp 2/1", dbg_wait_cnt, hazard); end
      rst = 1'b1; #1;
      vectors++; if ({dbg_state, dbg_wait_cnt, hazard, sb_err} !== {ARB_PIPE, 3'd0, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL rstmid_clear: got st=%0d cnt=%0d hz=%b err=%b exp 0/0/0/0", dbg_state, dbg_wait_cnt, hazard, sb_err); end
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

`ifdef RF_WB_FWD_EN
   task automatic test_fwd();
      iss_valid = 1; iss_rd = 5'd7;
      tick();
      iss_valid = 0;
      mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'hF00D; rs2 = 5'd7; #1;
      vectors++; if ({hazard, fwd_rs2, fwd_rs1, fwd_data} !== {3'b010, 32'hF00D}) begin
         miscompares++; $display("FAIL fwd_rs2: got hz=%b f2=%b f1=%b d=%h exp 0/1/0/f00d", hazard, fwd_rs2, fwd_rs1, fwd_data); end
      tick();
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_issue_hazard();
      test_iss_busy();
      test_force();
      test_x0();
      test_sb_err();
      test_reset_mid();
`ifdef RF_WB_FWD_EN
      test_fwd();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
